// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU responder:
//   - opcode encodings (same as the combinational ALU)
//   - FSM state encoding for alu_op_server
//   - is_legal_op() helper used to raise the illegal-op flag
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_half_slice.sv
// alu_half_slice
// Combinational HALF-bit ALU slice. The server runs it twice per operation,
// once on the low halves and once on the high halves.
// Ports:
//   a, b     in  HALF  operand halves
//   op       in  3     opcode
//   cin      in  1     carry into this half
//   y        out HALF  logic result (AND/OR) or adder sum (ADD/SUB/SLT)
//   cout     out 1     carry out of this half
//   sum_msb  out 1     top bit of the adder sum (sign bit when this is the high half)
module alu_half_slice
  import alu_pkg::*;
#(
  parameter int HALF = 16
) (
  input  logic [HALF-1:0] a,
  input  logic [HALF-1:0] b,
  input  logic [2:0]      op,
  input  logic            cin,
  output logic [HALF-1:0] y,
  output logic            cout,
  output logic            sum_msb
);

  logic [HALF-1:0] b_eff;
  logic [HALF:0]   sum_ext;

  // SUB and SLT both compute a - b as a + ~b + 1; the +1 arrives as cin of the low half.
  always_comb begin
    b_eff   = ((op == OP_SUB) || (op == OP_SLT)) ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{HALF{1'b0}}, cin};
    cout    = sum_ext[HALF];
    sum_msb = sum_ext[HALF-1];
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = sum_ext[HALF-1:0];
    endcase
  end

endmodule

// File: rtl/alu_op_server.sv
// alu_op_server
// Sequential ALU responder. Takes one (a, b, op) request over a valid/ready
// handshake, computes it in two HALF-bit passes through one shared slice, and
// holds the result and flags on a second valid/ready handshake until taken.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_a, req_b, req_op     request payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_z                    result
//   rsp_zero                 rsp_z == 0
//   rsp_ovf                  signed overflow (ADD/SUB only)
//   rsp_illegal              opcode outside the supported set
module alu_op_server
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_illegal
);

  localparam int HALF = WIDTH / 2;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [HALF-1:0]  lo_q;

  logic [HALF-1:0]  slice_a, slice_b, slice_y;
  logic             slice_cin, slice_cout, slice_msb;

  logic             b_sign_eff;
  logic             ovf_raw;
  logic [WIDTH-1:0] result_next;
  logic             ovf_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_LOW;
      end
      S_LOW:  state_next = S_HIGH;
      S_HIGH: state_next = S_DONE;
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The slice sees the high halves in HIGH and the low halves otherwise.
  // The low pass of SUB/SLT injects the +1 of the two's-complement negate.
  always_comb begin
    if (state == S_HIGH) begin
      slice_a   = a_q[WIDTH-1:HALF];
      slice_b   = b_q[WIDTH-1:HALF];
      slice_cin = carry_q;
    end else begin
      slice_a   = a_q[HALF-1:0];
      slice_b   = b_q[HALF-1:0];
      slice_cin = (op_q == OP_SUB) || (op_q == OP_SLT);
    end
  end

  alu_half_slice #(.HALF(HALF)) u_slice (
    .a       (slice_a),
    .b       (slice_b),
    .op      (op_q),
    .cin     (slice_cin),
    .y       (slice_y),
    .cout    (slice_cout),
    .sum_msb (slice_msb)
  );

  // Final result during HIGH. slice_msb is then the sign of the full sum, so
  // overflow is "operands agree in sign, sum disagrees". SLT reuses the SUB
  // overflow to correct the sign of the difference.
  always_comb begin
    b_sign_eff  = (op_q == OP_ADD) ? b_q[WIDTH-1] : ~b_q[WIDTH-1];
    ovf_raw     = (a_q[WIDTH-1] == b_sign_eff) && (slice_msb != a_q[WIDTH-1]);
    result_next = '0;
    ovf_next    = 1'b0;
    case (op_q)
      OP_AND, OP_OR: result_next = {slice_y, lo_q};
      OP_ADD, OP_SUB: begin
        result_next = {slice_y, lo_q};
        ovf_next    = ovf_raw;
      end
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, slice_msb ^ ovf_raw};
      default: result_next = '0;
    endcase
  end

  // Operand capture, low-half result and carry, and the response registers.
  // Response registers are written only on the HIGH->DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      lo_q        <= '0;
      rsp_z       <= '0;
      rsp_zero    <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q  <= req_a;
            b_q  <= req_b;
            op_q <= req_op;
          end
        end
        S_LOW: begin
          lo_q    <= slice_y;
          carry_q <= slice_cout;
        end
        S_HIGH: begin
          rsp_z       <= result_next;
          rsp_zero    <= (result_next == '0);
          rsp_ovf     <= ovf_next;
          rsp_illegal <= !is_legal_op(op_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_server.sv
// tb_alu_op_server
// Scoreboard bench for alu_op_server: expected responses are queued when a
// request is accepted and popped when the matching response is taken.
module tb_alu_op_server;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] z;
    logic        zero;
    logic        ovf;
    logic        illegal;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_illegal;

  int   checks;
  int   failures;
  rsp_t exp_q[$];

  alu_op_server #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .rsp_zero    (rsp_zero),
    .rsp_ovf     (rsp_ovf),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on 64-bit signed arithmetic.
  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    rsp_t   m;
    longint sa, sb, r;
    m  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    case (op)
      3'b000: m.z = a & b;
      3'b001: m.z = a | b;
      3'b010: begin
        m.z = a + b;
        r = sa + sb;
        m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b110: begin
        m.z = a - b;
        r = sa - sb;
        m.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: m.z = (sa < sb) ? 32'd1 : 32'd0;
      default: m.illegal = 1'b1;
    endcase
    m.zero = (m.z == 32'd0);
    return m;
  endfunction

  function automatic logic [2:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return OP_AND;
      1:       return OP_OR;
      2:       return OP_ADD;
      3:       return OP_SUB;
      default: return OP_SLT;
    endcase
  endfunction

  function automatic rsp_t observed();
    return {rsp_z, rsp_zero, rsp_ovf, rsp_illegal};
  endfunction

  // Drives one request, waits for its response, optionally stalls, then takes it.
  // Starts and ends at a falling edge with the DUT idle.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input int stall, output rsp_t obs, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    obs = '0;
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, op));
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) return;
    obs = observed();
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    checks++;
    if (observed() !== rsp_t'(0)) begin failures++; $display("[TB] FAIL reset_outputs got %h expected 0", observed()); end
  endtask

  task automatic test_add_carry();
    rsp_t obs, exp;
    int   lat;
    bit   ok;
    do_txn(32'h0000FFFF, 32'h00000001, OP_ADD, 0, obs, lat, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL add_timeout got no response expected one"); exp_q.delete();
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin failures++; $display("[TB] FAIL add_carry got %h expected %h", obs, exp); end
      checks++;
      if (obs.z !== 32'h00010000) begin failures++; $display("[TB] FAIL add_const got %h expected 00010000", obs.z); end
      checks++;
      if (lat !== 2) begin failures++; $display("[TB] FAIL add_latency got %0d expected 2", lat); end
    end
  endtask

  task automatic test_reset_mid_op();
    req_a = 32'h11111111;
    req_b = 32'h22222222;
    req_op = OP_OR;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midop_handshake got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
    end
    checks++;
    if (observed() !== rsp_t'(0)) begin failures++; $display("[TB] FAIL midop_outputs got %h expected 0", observed()); end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_no_rsp got %b expected 0", rsp_valid); end
  endtask

  task automatic test_sub();
    logic [31:0] va[2] = '{32'h12345678, 32'h80000000};
    logic [31:0] vb[2] = '{32'h12345678, 32'h00000001};
    rsp_t obs, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 2; i++) begin
      do_txn(va[i], vb[i], OP_SUB, 0, obs, lat, ok);
      checks++;
      if (!ok) begin
        failures++; $display("[TB] FAIL sub_timeout[%0d] got no response expected one", i); exp_q.delete();
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin failures++; $display("[TB] FAIL sub[%0d] got %h expected %h", i, obs, exp); end
      end
    end
  endtask

  task automatic test_slt();
    logic [31:0] va[3] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000};
    logic [31:0] vb[3] = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] vz[3] = '{32'd1, 32'd0, 32'd1};
    rsp_t obs, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      do_txn(va[i], vb[i], OP_SLT, 1, obs, lat, ok);
      checks++;
      if (!ok) begin
        failures++; $display("[TB] FAIL slt_timeout[%0d] got no response expected one", i); exp_q.delete();
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp || obs.z !== vz[i]) begin
          failures++; $display("[TB] FAIL slt[%0d] got %h expected %h (z=%h)", i, obs, exp, vz[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] vops[3] = '{3'b101, 3'b011, 3'b100};
    rsp_t obs, exp;
    int   lat;
    bit   ok;
    for (int i = 0; i < 3; i++) begin
      do_txn(32'hDEADBEEF, 32'h12345678, vops[i], 0, obs, lat, ok);
      checks++;
      if (!ok) begin
        failures++; $display("[TB] FAIL illegal_timeout[%0d] got no response expected one", i); exp_q.delete();
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp || lat !== 2) begin
          failures++; $display("[TB] FAIL illegal[%0d] got %h lat=%0d expected %h lat=2", i, obs, lat, exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t exp;
    req_a = 32'hF0F0F0F0;
    req_b = 32'h0FF00FF0;
    req_op = OP_AND;
    req_valid = 1'b1;
    exp_q.push_back(model(req_a, req_b, req_op));
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    exp = exp_q.pop_front();
    // A competing request is offered during the stall and must not be taken.
    req_a = 32'h00000005;
    req_b = 32'h00000003;
    req_op = OP_ADD;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || observed() !== exp || exp.z !== 32'h00F000F0) begin
        failures++;
        $display("[TB] FAIL backpressure[%0d] got valid=%b ready=%b rsp=%h expected valid=1 ready=0 rsp=%h",
                 i, rsp_valid, req_ready, observed(), exp);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL backpressure_release got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  // Requests held valid and rsp_ready held high: one acceptance every 4 cycles.
  task automatic test_back_to_back();
    int   sent = 0, rcvd = 0, cyc = 0, last = -1;
    bit   acc;
    rsp_t exp;
    rsp_ready = 1'b1;
    req_a = 32'h7FFFFFFF;
    req_b = 32'h00000001;
    req_op = OP_ADD;
    req_valid = 1'b1;
    while (rcvd < 4 && cyc < 100) begin
      if (rsp_valid) begin
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : rsp_t'(0);
        if (observed() !== exp) begin failures++; $display("[TB] FAIL b2b_rsp[%0d] got %h expected %h", rcvd, observed(), exp); end
        rcvd++;
      end
      acc = req_valid && req_ready;
      if (acc) begin
        exp_q.push_back(model(req_a, req_b, req_op));
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 4) begin failures++; $display("[TB] FAIL b2b_gap got %0d expected 4", cyc - last); end
        end
        last = cyc;
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        req_a = req_a + 32'h01010101;
        req_b = ~req_b;
        req_op = (req_op == OP_ADD) ? OP_SUB : OP_ADD;
        req_valid = (sent < 4);
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rcvd !== 4) begin failures++; $display("[TB] FAIL b2b_count got %0d expected 4", rcvd); end
  endtask

  task automatic test_random();
    int   sent = 0, rcvd = 0, cyc = 0;
    bit   acc;
    rsp_t exp;
    exp_q.delete();
    rsp_ready = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    req_op = pick_op();
    req_valid = 1'b1;
    while ((sent < 500 || rcvd < sent) && cyc < 20000) begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL rand_unexpected got %h expected no response", observed());
        end else begin
          exp = exp_q.pop_front();
          if (observed() !== exp) begin failures++; $display("[TB] FAIL rand[%0d] got %h expected %h", rcvd, observed(), exp); end
        end
        rcvd++;
      end
      acc = req_valid && req_ready;
      if (acc) begin
        exp_q.push_back(model(req_a, req_b, req_op));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc || !req_valid) begin
        if (sent < 500 && $urandom_range(0, 3) != 0) begin
          req_a = $urandom;
          req_b = ($urandom_range(0, 7) == 0) ? req_a : $urandom;
          req_op = pick_op();
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
      rsp_ready = $urandom_range(0, 1);
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (sent !== 500 || rcvd !== 500) begin
      failures++; $display("[TB] FAIL rand_count got sent=%0d rcvd=%0d expected 500/500", sent, rcvd);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_carry();
    test_reset_mid_op();
    test_sub();
    test_slt();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
